// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-vector layout, stall codes and sequencer states for pipe_stall_ctrl.
package pipe_stall_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges load-use, mult/div and flush requests,
// runs the mult/div start/done handshake with timeout, and counts stall cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned TMR_W      = 7,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_stallreq,
  input  logic               ex_md_req,
  input  logic               flush_req,
  input  logic               md_done,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               md_start,
  output logic               md_abort,
  output logic               md_result_valid,
  output logic               md_err,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic             res_ok_q, res_ok_d;

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    err_d           = err_q;
    res_ok_d        = res_ok_q;
    stall           = STALL_NONE;
    flush           = 1'b0;
    md_start        = 1'b0;
    md_abort        = 1'b0;
    md_result_valid = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            flush = 1'b1;
          end else if (ex_md_req) begin
            md_start = 1'b1;
            stall    = STALL_EX;
            state_d  = ST_MD_WAIT;
            timer_d  = '0;
          end else if (id_stallreq) begin
            stall = STALL_ID;
          end
        end
        ST_MD_WAIT: begin
          if (flush_req) begin
            flush    = 1'b1;
            md_abort = 1'b1;
            state_d  = ST_IDLE;
            timer_d  = '0;
          end else begin
            stall   = STALL_EX;
            timer_d = timer_q + 1'b1;
            // done is tested before timeout so a same-cycle done wins
            if (md_done) begin
              state_d  = ST_MD_DONE;
              res_ok_d = 1'b1;
            end else if (timer_q == TMR_LAST) begin
              md_abort = 1'b1;
              err_d    = 1'b1;
              state_d  = ST_MD_DONE;
              res_ok_d = 1'b0;
            end
          end
        end
        ST_MD_DONE: begin
          md_result_valid = res_ok_q;
          state_d         = ST_IDLE;
          if (flush_req)        flush = 1'b1;
          else if (id_stallreq) stall = STALL_ID;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      err_q    <= 1'b0;
      res_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      res_ok_q <= res_ok_d;
    end
  end

  assign md_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (|stall),
    .q   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized self-checking bench for pipe_stall_ctrl against a cycle-level reference model.
module tb_pipe_stall_ctrl;

  localparam int unsigned MD_TIMEOUT = 8;
  localparam int unsigned TMR_W      = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_stallreq = 1'b0, ex_md_req = 1'b0, flush_req = 1'b0, md_done = 1'b0;
  logic [5:0]       stall;
  logic             flush, md_start, md_abort, md_result_valid, md_err;
  logic [CNT_W-1:0] stall_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model: is an op waiting, how many wait cycles it has used,
  // is an op retiring this cycle and did it finish with a result
  bit          m_waiting, m_retiring, m_ok, m_err;
  int unsigned m_waited, m_cnt;

  pipe_stall_ctrl #(
    .MD_TIMEOUT(MD_TIMEOUT),
    .TMR_W     (TMR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_stallreq    (id_stallreq),
    .ex_md_req      (ex_md_req),
    .flush_req      (flush_req),
    .md_done        (md_done),
    .stall          (stall),
    .flush          (flush),
    .md_start       (md_start),
    .md_abort       (md_abort),
    .md_result_valid(md_result_valid),
    .md_err         (md_err),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_retiring = 0; m_ok = 0; m_err = 0; m_waited = 0; m_cnt = 0;
  endtask

  // drive one cycle's inputs, check all outputs, then advance the model over the edge
  task automatic step(input bit r, input bit id, input bit ex, input bit fl, input bit dn);
    bit [5:0] e_stall;
    bit e_flush, e_start, e_abort, e_valid, timeout;
    @(negedge clk);
    rst = r; id_stallreq = id; ex_md_req = ex; flush_req = fl; md_done = dn;
    #1;
    e_stall = 6'b0; e_flush = 0; e_start = 0; e_abort = 0; e_valid = 0; timeout = 0;
    if (!r) begin
      if (m_retiring) e_valid = m_ok;
      if (fl) begin
        e_flush = 1;
        e_abort = m_waiting;
      end else if (m_waiting) begin
        e_stall = 6'b001111;
        timeout = !dn && (m_waited + 1 == MD_TIMEOUT);
        e_abort = timeout;
      end else if (m_retiring) begin
        if (id) e_stall = 6'b000111;
      end else if (ex) begin
        e_start = 1;
        e_stall = 6'b001111;
      end else if (id) begin
        e_stall = 6'b000111;
      end
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("md_start", 32'(md_start), 32'(e_start));
    chk("md_abort", 32'(md_abort), 32'(e_abort));
    chk("md_result_valid", 32'(md_result_valid), 32'(e_valid));
    chk("md_err", 32'(md_err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (r) begin
      model_reset();
    end else begin
      if (e_stall != 0 && m_cnt < CNT_MAX) m_cnt++;
      if (timeout) m_err = 1;
      if (m_waiting) begin
        if (fl) begin
          m_waiting = 0;
        end else if (dn || timeout) begin
          m_waiting = 0; m_retiring = 1; m_ok = dn;
        end else begin
          m_waited++;
        end
      end else if (m_retiring) begin
        m_retiring = 0;
      end else if (e_start) begin
        m_waiting = 1; m_waited = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0);
    // load-use bubble
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // mult/div done on 5th wait cycle, then back to idle
    step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // timeout with done never arriving
    step(0, 0, 1, 0, 0);
    repeat (MD_TIMEOUT) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // flush on the 3rd wait cycle, later done ignored
    step(0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    // done coinciding with the timeout cycle, load-use in the retire cycle
    step(0, 0, 1, 0, 0);
    repeat (MD_TIMEOUT - 1) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // saturate the stall counter, then reset
    repeat (CNT_MAX + 4) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    // random traffic
    for (int unsigned i = 0; i < 4000; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 35,
           $urandom_range(99) < 5, $urandom_range(99) < 14);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
